// File: rtl/mem_access_arbiter_if.sv
// rtl/mem_access_arbiter_if.sv - requester and byte-RAM signal bundle for mem_access_arbiter
interface mem_access_arbiter_if;
  logic        valid0;
  logic        valid1;
  logic        rw0;
  logic        rw1;
  logic [1:0]  size0;
  logic [1:0]  size1;
  logic [7:0]  addr0;
  logic [7:0]  addr1;
  logic [31:0] wdata0;
  logic [31:0] wdata1;
  logic        done0;
  logic        done1;
  logic [31:0] rdata;
  logic        err;
  logic        busy;
  logic        ram_en;
  logic        ram_rw;
  logic [7:0]  ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  // Arbiter side: takes requests and RAM read data, drives completions and RAM strobes
  modport slave (
    input  valid0, valid1, rw0, rw1, size0, size1, addr0, addr1, wdata0, wdata1, ram_rdata,
    output done0, done1, rdata, err, busy, ram_en, ram_rw, ram_addr, ram_wdata
  );

  // Requester/RAM side
  modport master (
    output valid0, valid1, rw0, rw1, size0, size1, addr0, addr1, wdata0, wdata1, ram_rdata,
    input  done0, done1, rdata, err, busy, ram_en, ram_rw, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_access_arbiter.sv
// rtl/mem_access_arbiter.sv - two-port byte-serial RAM arbiter, big-endian; MEM_ARB_RR_EN selects round-robin
module mem_access_arbiter (
  input logic                  clk,
  input logic                  rst_n,
  mem_access_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DONE = 2'd2} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_port;
  logic        r_rw;
  logic        r_err;
  logic [1:0]  r_size;
  logic [1:0]  r_k;
  logic [7:0]  r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_acc;
  logic [31:0] r_rdata;

  logic        w_req;
  logic        w_grant;
  logic        w_sel;
  logic        w_sel_rw;
  logic [1:0]  w_sel_size;
  logic [7:0]  w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic [1:0]  w_nm1;
  logic [1:0]  w_byte_idx;
  logic        w_last;
  logic [7:0]  w_wbyte;
  logic [31:0] w_result;

  assign w_req   = bus.valid0 | bus.valid1;
  assign w_grant = (r_state == IDLE) && w_req;

`ifdef MEM_ARB_RR_EN
  logic r_prio;

  assign w_sel = (bus.valid0 && bus.valid1) ? r_prio : bus.valid1;

  // Priority pointer: after each grant the other port gets preference
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= 1'b0;
    end else if (w_grant) begin
      r_prio <= ~w_sel;
    end
  end
`else
  assign w_sel = ~bus.valid0;
`endif

  assign w_sel_rw    = w_sel ? bus.rw1    : bus.rw0;
  assign w_sel_size  = w_sel ? bus.size1  : bus.size0;
  assign w_sel_addr  = w_sel ? bus.addr1  : bus.addr0;
  assign w_sel_wdata = w_sel ? bus.wdata1 : bus.wdata0;

  assign w_last     = (r_k == w_nm1);
  assign w_byte_idx = w_nm1 - r_k;
  assign w_result   = (r_rw || r_err) ? 32'h0 : r_acc;

  // Index of the final byte for the latched size; MSB goes out first
  always_comb begin
    w_nm1   = 2'd3;
    w_wbyte = 8'h00;
    case (r_size)
      2'b00:   w_nm1 = 2'd0;
      2'b01:   w_nm1 = 2'd1;
      default: w_nm1 = 2'd3;
    endcase
    case (w_byte_idx)
      2'd0:    w_wbyte = r_wdata[7:0];
      2'd1:    w_wbyte = r_wdata[15:8];
      2'd2:    w_wbyte = r_wdata[23:16];
      default: w_wbyte = r_wdata[31:24];
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: illegal size skips the RAM entirely
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_state_nxt = (w_sel_size == 2'b11) ? DONE : XFER;
        end
      end
      XFER: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; RAM lines stay at zero outside XFER
  always_comb begin
    bus.done0     = 1'b0;
    bus.done1     = 1'b0;
    bus.err       = 1'b0;
    bus.rdata     = r_rdata;
    bus.busy      = (r_state != IDLE);
    bus.ram_en    = 1'b0;
    bus.ram_rw    = 1'b0;
    bus.ram_addr  = 8'h00;
    bus.ram_wdata = 8'h00;
    if (r_state == XFER) begin
      bus.ram_en    = 1'b1;
      bus.ram_rw    = r_rw;
      bus.ram_addr  = r_addr + {6'b0, r_k};
      bus.ram_wdata = r_rw ? w_wbyte : 8'h00;
    end
    if (r_state == DONE) begin
      bus.done0 = ~r_port;
      bus.done1 = r_port;
      bus.err   = r_err;
      bus.rdata = w_result;
    end
  end

  // Request latch, byte counter, read accumulator and held result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_port  <= 1'b0;
      r_rw    <= 1'b0;
      r_err   <= 1'b0;
      r_size  <= 2'b00;
      r_k     <= 2'd0;
      r_addr  <= 8'h00;
      r_wdata <= 32'h0;
      r_acc   <= 32'h0;
      r_rdata <= 32'h0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_port  <= w_sel;
            r_rw    <= w_sel_rw;
            r_size  <= w_sel_size;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_err   <= (w_sel_size == 2'b11);
            r_k     <= 2'd0;
            r_acc   <= 32'h0;
          end
        end
        XFER: begin
          r_k <= r_k + 2'd1;
          if (!r_rw) begin
            r_acc <= {r_acc[23:0], bus.ram_rdata};
          end
        end
        DONE: begin
          r_rdata <= w_result;
        end
        default: ;
      endcase
    end
  end

endmodule
